// File: rtl/sram_pkg.sv
// Shared SRAM widths and writer state encoding.
// Used by the SRAM writer and its stream interface.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } wr_state_t;

  function automatic logic is_busy(wr_state_t s);
    return (s == SETUP) || (s == PULSE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/sram_writing_fsm_if.sv
// Sample stream handshake and status of the SRAM writer.
// master = sample source, slave = writer.
interface sram_writing_fsm_if
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) ();

  logic              enable;
  logic              restart;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic [ADDR_W:0]   words_written;
  logic              done;

  modport master (
    output enable,
    output restart,
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  words_written,
    input  done
  );

  modport slave (
    input  enable,
    input  restart,
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output words_written,
    output done
  );

endinterface

// File: rtl/sram_writing_fsm.sv
// Streams samples into async SRAM, one word per address from 0.
// Each write: SETUP, WE_CYCLES of WE_N low, HOLD, then count.
module sram_writing_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int DEPTH     = 1 << SRAM_ADDR_W,
  parameter int WE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  sram_writing_fsm_if.slave bus,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  localparam int CW =
    (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CW-1:0] WE_LAST =
    CW'(WE_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(DEPTH - 1);

  wr_state_t         state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     we_cnt_q, we_cnt_d;
  logic              busy;

  assign busy = is_busy(state_q);

  // State, counter and latched sample registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      data_q   <= '0;
      we_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      we_cnt_q <= we_cnt_d;
    end
  end

  // Next-state logic; restart only acts when no write is in flight.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    we_cnt_d = we_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.restart) begin
          count_d = '0;
        end else if (bus.sample_ready && bus.sample_valid) begin
          data_d  = bus.sample_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        we_cnt_d = '0;
        state_d  = PULSE;
      end
      PULSE: begin
        if (we_cnt_q == WE_LAST) begin
          state_d = HOLD;
        end else begin
          we_cnt_d = we_cnt_q + CW'(1);
        end
      end
      HOLD: begin
        count_d = count_q + (ADDR_W + 1)'(1);
        state_d = (count_d == DEPTH_C) ? DONE : IDLE;
      end
      DONE: begin
        if (bus.restart) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sample_ready =
    (state_q == IDLE) && bus.enable && !bus.restart;
  assign bus.done          = (state_q == DONE);
  assign bus.words_written = count_q;

  // In DONE the counter equals DEPTH; park ADDR on the last word.
  assign SRAM_ADDR = (state_q == DONE) ? LAST_ADDR
                                       : count_q[ADDR_W-1:0];

  assign SRAM_CE_N = !(bus.enable || busy);
  assign SRAM_UB_N = !busy;
  assign SRAM_LB_N = !busy;
  assign SRAM_OE_N = 1'b1;
  assign SRAM_WE_N = (state_q != PULSE);

  assign SRAM_DQ = busy ? data_q : {DATA_W{1'bz}};

endmodule

// File: doc/sram_writing_fsm.md
Name: sram_writing_fsm

Overview:
- Loads a stream of 16-bit audio samples into the external 1M x 16 async SRAM, one word per address, starting at address 0 after reset or restart.
- Write-side counterpart of the sequential SRAM playback reader; fills the memory the reader later plays back.
- Sits between the sample source (loader/decoder, valid/ready stream) and the SRAM pins; the top level muxes SRAM control between writer and reader.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- DEPTH, 1048576, number of words to write before done; 1 <= DEPTH <= 2**ADDR_W.
- WE_CYCLES, 2, Clk cycles SRAM_WE_N is held low per write; >= 1.

Ports:
- Clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  writer may accept samples while high.
- restart  input  1  synchronous pulse; rearms to address 0.
- sample_in  input  DATA_W  sample data.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  writer accepts sample this cycle.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM controls.
- SRAM_ADDR  output  ADDR_W  SRAM address.
- SRAM_DQ  inout  DATA_W  SRAM data bus; driven only during a write, high-Z otherwise.
- words_written  output  ADDR_W+1  count of completed writes.
- done  output  1  DEPTH words have been written.

Behaviour:
- Reset (async, immediate): state IDLE; CE_N=UB_N=LB_N=OE_N=WE_N=1; SRAM_ADDR=0; SRAM_DQ high-Z; sample_ready=0; words_written=0; done=0.
- OE_N stays 1 at all times; the writer never reads.
- CE_N=0 whenever enable=1 or the state is not IDLE/DONE.
- States:
  - IDLE: sample_ready = enable && !done && !restart. On sample_valid && sample_ready, latch sample_in and go to SETUP.
  - SETUP (1 cycle): drive SRAM_DQ with the latched word; UB_N=LB_N=0; WE_N=1; ADDR = words_written[ADDR_W-1:0].
  - PULSE (WE_CYCLES cycles): WE_N=0; ADDR and DQ stable.
  - HOLD (1 cycle): WE_N=1; DQ and ADDR still driven. On exit, words_written += 1. If the new count == DEPTH go to DONE, else go to IDLE.
  - DONE: done=1; sample_ready=0; DQ high-Z; UB_N=LB_N=1.
- Timing: accept on cycle n; SETUP at n+1; WE_N low n+2 .. n+1+WE_CYCLES; HOLD at n+2+WE_CYCLES; sample_ready can be high again at n+3+WE_CYCLES. Throughput is one word per WE_CYCLES+3 cycles.
- sample_ready is 0 outside IDLE. Valid samples presented while busy are not consumed; the source must hold them.
- Address never wraps: the counter is ADDR_W+1 bits, so DEPTH = 2**ADDR_W terminates cleanly at the last address.
- enable falling mid-write: the current write completes; no further accepts.
- restart:
  - In IDLE or DONE: next cycle words_written=0, SRAM_ADDR=0, done=0, state IDLE.
  - In SETUP/PULSE/HOLD: ignored; the write completes and the count increments.
  - restart and sample_valid in the same IDLE cycle: restart wins and nothing is accepted.
- Reset mid-write: WE_N returns high and DQ goes high-Z asynchronously. The partial word is undefined and is not counted.

Decomposition:
- Shared package sram_pkg: SRAM_ADDR_W=20, SRAM_DATA_W=16, and the writer state typedef enum {IDLE, SETUP, PULSE, HOLD, DONE}.
- Single module, no sub-module needed. The tri-state is an inline continuous assignment gated by the SETUP/PULSE/HOLD state.

Test Plan:
- Reset, then enable=1, one sample 16'hA5A5 accepted at cycle 0 -> ADDR=0, DQ=A5A5 from cycle 1; WE_N low cycles 2-3 (WE_CYCLES=2); words_written=1 after cycle 4; ready high at cycle 5.
- Continuous valid stream 0x0001..0x0004 -> words written to addresses 0..3, one every 5 cycles, DQ high-Z between writes; SRAM model contents match.
- DEPTH=4, keep streaming -> done=1 after the 4th HOLD, sample_ready stays 0, the 5th sample is never consumed, ADDR does not advance to 4.
- Assert reset while WE_N is low -> WE_N=1 and DQ=Z in the same cycle; ADDR=0 and words_written=0; the next write targets address 0.
- In DONE, pulse restart -> done=0, words_written=0, ready=1 the following cycle; restart during PULSE -> write completes and the count increments.
- enable=0 with sample_valid=1 -> sample_ready=0, WE_N stays 1, CE_N=1, nothing written.
